pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Central pipeline controller for the 5-stage MIPS core.
- Merges per-stage stall requests into the 6-bit stall vector that drives pc_reg, if_id, id_ex, ex_mem and mem_wb.
- Sequences precise-exception handling: freeze, wait for an in-flight data bus access, one-cycle flush, redirect the PC.
- Provides a saturating stall-cycle performance counter and a stall watchdog.

Parameters:
- EXC_VECTOR, 32'h00000020, target PC for every exception except eret.
- WDOG_LIMIT, 1024, number of consecutive stalled cycles that trips the watchdog.
- CNT_W, 32, width of the stall-cycle counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- stallreq_from_if  in  1  instruction bus busy
- stallreq_from_id  in  1  load-use hazard
- stallreq_from_ex  in  1  multi-cycle op (madd/msub/div) busy
- stallreq_from_mem  in  1  data bus transaction in flight
- excepttype_i  in  32  exception code of the instruction in MEM; 0 = none
- cp0_epc_i  in  32  current CP0 EPC
- stall  out  6  [0]=PC, [1]=IF, [2]=ID, [3]=EX, [4]=MEM, [5]=WB hold
- flush  out  1  clear all pipeline registers
- new_pc  out  32  redirect target, valid while flush=1
- exc_busy_o  out  1  state != IDLE
- stall_cycles_o  out  CNT_W  count of cycles with stall[0]=1
- wdog_o  out  1  sticky watchdog trip

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk. All state updates on posedge clk.
- Reset values: state=IDLE, flush=0, new_pc=0, exc_busy_o=0, stall_cycles_o=0, wdog_o=0, watchdog count=0, latched code/EPC=0. While rst=1, stall=6'b000000.
- FSM has three states: IDLE, WAIT, FLUSH.
- IDLE, excepttype_i==0: stall is combinational in the same cycle, by priority:
  - mem request -> 011111
  - ex request -> 001111
  - id request -> 000111
  - if request -> 000111
  - none -> 000000
- IDLE, excepttype_i!=0:
  - Latch excepttype_i and cp0_epc_i.
  - stall=111111 in the detect cycle; the exception overrides every stall request.
  - Next state is WAIT if stallreq_from_mem=1, else FLUSH.
- WAIT:
  - stall=111111 and excepttype_i is ignored.
  - Move to FLUSH on the first cycle where stallreq_from_mem=0, sampled at that edge.
- FLUSH (exactly one cycle):
  - flush=1 and stall=000000.
  - new_pc = latched EPC if latched code==32'h0000000E (eret), else EXC_VECTOR.
  - excepttype_i is ignored because it belongs to a flushed instruction.
  - Next state is IDLE.
- flush, new_pc and exc_busy_o are Moore outputs decoded from registered state and latches. new_pc holds its last value outside FLUSH.
- Latency:
  - Exception with mem idle: detect cycle, then flush on the next cycle.
  - With mem busy: flush on the cycle after stallreq_from_mem is first sampled low.
- stall_cycles_o: +1 each cycle stall[0]=1, including freeze cycles; saturates at all-ones.
- Watchdog:
  - Counts consecutive stall[0]=1 cycles and clears on any stall[0]=0 cycle.
  - Count saturates at WDOG_LIMIT.
  - wdog_o is set when the count reaches WDOG_LIMIT and stays set until rst.
- Reset in mid-WAIT or mid-FLUSH returns to IDLE with all outputs at reset values on the next cycle.

Decomposition:
- Shared defines file holds:
  - stall vector encodings STALL_NONE / STALL_IF_ID / STALL_EX / STALL_MEM / STALL_ALL;
  - exception codes EXC_INT=1, SYSCALL=8, INST_INVALID=9, TRAP=0xD, OV=0xC, ERET=0xE;
  - FSM state encodings.
- One natural sub-module, sat_counter (parameterised width, increment, clear, saturation), instantiated twice: perf counter and watchdog.

Test Plan:
- Reset, then drive each stallreq alone -> stall = 000111 (if), 000111 (id), 001111 (ex), 011111 (mem) in the same cycle; all four high -> 011111.
- excepttype_i=0x8, mem idle -> stall=111111 in cycle N, flush=1 with new_pc=0x20 in N+1, stall=000000, idle in N+2.
- excepttype_i=0xE, cp0_epc_i=0x1000, stallreq_from_mem high for 3 more cycles -> stall=111111 throughout, exc_busy_o=1, flush=1 with new_pc=0x1000 one cycle after mem drops.
- Exception held during FLUSH and during WAIT -> no second flush and no re-latch; new_pc keeps its first value.
- stallreq_from_ex held 1024 cycles with WDOG_LIMIT=1024 -> wdog_o=1 and stays 1 after the request drops; stall_cycles_o=1024.
- rst asserted in WAIT -> next cycle state IDLE, flush=0, counters 0, and no flush is issued afterwards.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared definitions for the pipeline controller.
//   - stall vector encodings ([0]=PC .. [5]=WB hold)
//   - MIPS exception codes as they appear on excepttype_i
//   - exception-sequencer FSM state encoding
//   - stall_merge(): priority merge of per-stage stall requests
package pipe_ctrl_pkg;

   localparam logic [5:0] STALL_NONE  = 6'b000000;
   localparam logic [5:0] STALL_IF_ID = 6'b000111;
   localparam logic [5:0] STALL_EX    = 6'b001111;
   localparam logic [5:0] STALL_MEM   = 6'b011111;
   localparam logic [5:0] STALL_ALL   = 6'b111111;

   localparam logic [31:0] EXC_INT          = 32'h0000_0001;
   localparam logic [31:0] EXC_SYSCALL      = 32'h0000_0008;
   localparam logic [31:0] EXC_INST_INVALID = 32'h0000_0009;
   localparam logic [31:0] EXC_TRAP         = 32'h0000_000D;
   localparam logic [31:0] EXC_OV           = 32'h0000_000C;
   localparam logic [31:0] EXC_ERET         = 32'h0000_000E;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_FLUSH = 2'd2
   } state_e;

   // The deepest requesting stage wins: holding a later stage must also
   // hold everything in front of it. IF and ID share an encoding because
   // an instruction-fetch miss cannot let ID advance either.
   function automatic logic [5:0] stall_merge(input logic req_if,
                                              input logic req_id,
                                              input logic req_ex,
                                              input logic req_mem);
      if (req_mem)               return STALL_MEM;
      else if (req_ex)           return STALL_EX;
      else if (req_id || req_if) return STALL_IF_ID;
      else                       return STALL_NONE;
   endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// sat_counter: synchronous up-counter that sticks at MAX.
//   clk, rst  - clock, synchronous active-high reset (count -> 0)
//   inc_i     - add one this cycle unless already at MAX
//   clr_i     - return to zero this cycle; wins over inc_i
//   count_o   - current count
module sat_counter #(
   parameter int               WIDTH = 8,
   parameter logic [WIDTH-1:0] MAX   = '1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [WIDTH-1:0] count_o
);

   logic [WIDTH-1:0] count_q, count_d;

   // NOTE: every variable assigned in always_comb gets a default first;
   // otherwise an untaken branch would infer a latch.
   always_comb begin
      count_d = count_q;
      if (clr_i)
         count_d = '0;
      else if (inc_i && (count_q != MAX))
         count_d = count_q + WIDTH'(1);
   end

   // NOTE: flops take only non-blocking assignments so every register
   // samples its pre-edge inputs regardless of process ordering.
   always_ff @(posedge clk) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   end

   assign count_o = count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central pipeline controller for the 5-stage MIPS core.
//   clk, rst           - clock, synchronous active-high reset
//   stallreq_from_*    - per-stage stall requests (if, id, ex, mem)
//   excepttype_i       - exception code of the instruction in MEM, 0 = none
//   cp0_epc_i          - current CP0 EPC, return target for eret
//   stall              - hold vector [0]=PC .. [5]=WB
//   flush              - clear all pipeline registers (one cycle)
//   new_pc             - redirect target, valid while flush=1, held otherwise
//   exc_busy_o         - exception sequencer not idle
//   stall_cycles_o     - saturating count of cycles with stall[0]=1
//   wdog_o             - sticky: WDOG_LIMIT consecutive stalled cycles seen
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
   parameter int          WDOG_LIMIT = 1024,
   parameter int          CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stallreq_from_if,
   input  logic             stallreq_from_id,
   input  logic             stallreq_from_ex,
   input  logic             stallreq_from_mem,
   input  logic [31:0]      excepttype_i,
   input  logic [31:0]      cp0_epc_i,
   output logic [5:0]       stall,
   output logic             flush,
   output logic [31:0]      new_pc,
   output logic             exc_busy_o,
   output logic [CNT_W-1:0] stall_cycles_o,
   output logic             wdog_o
);

   localparam int              WD_W   = $clog2(WDOG_LIMIT + 1);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(WDOG_LIMIT);

   state_e      state_q, state_d;
   logic [31:0] code_q, code_d;
   logic [31:0] epc_q, epc_d;
   logic [31:0] new_pc_q, new_pc_d;
   logic        wdog_q, wdog_d;
   logic [5:0]  stall_c;
   logic [WD_W-1:0] wd_cnt;

   always_comb begin
      state_d  = state_q;
      code_d   = code_q;
      epc_d    = epc_q;
      new_pc_d = new_pc_q;
      stall_c  = STALL_NONE;

      unique case (state_q)
         ST_IDLE: begin
            if (excepttype_i != 32'd0) begin
               code_d  = excepttype_i;
               epc_d   = cp0_epc_i;
               stall_c = STALL_ALL;
               // A data access already on the bus must complete before the
               // pipeline may be cleared, or memory would see half a transfer.
               state_d = stallreq_from_mem ? ST_WAIT : ST_FLUSH;
            end else begin
               stall_c = stall_merge(stallreq_from_if, stallreq_from_id,
                                     stallreq_from_ex, stallreq_from_mem);
            end
         end
         ST_WAIT: begin
            stall_c = STALL_ALL;
            if (!stallreq_from_mem) state_d = ST_FLUSH;
         end
         ST_FLUSH: begin
            stall_c = STALL_NONE;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Target is registered on entry to FLUSH so new_pc is a clean flop
      // output; code_d/epc_d cover the direct IDLE->FLUSH path.
      if (state_d == ST_FLUSH)
         new_pc_d = (code_d == EXC_ERET) ? epc_d : EXC_VECTOR;

      if (rst) stall_c = STALL_NONE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         code_q   <= '0;
         epc_q    <= '0;
         new_pc_q <= '0;
         wdog_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         code_q   <= code_d;
         epc_q    <= epc_d;
         new_pc_q <= new_pc_d;
         wdog_q   <= wdog_d;
      end
   end

   sat_counter #(.WIDTH(CNT_W)) u_perf_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (stall_c[0]),
      .clr_i   (1'b0),
      .count_o (stall_cycles_o)
   );

   sat_counter #(.WIDTH(WD_W), .MAX(WD_MAX)) u_wdog_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (stall_c[0]),
      .clr_i   (!stall_c[0]),
      .count_o (wd_cnt)
   );

   // Trip on the same edge the watchdog count reaches the limit.
   always_comb begin
      wdog_d = wdog_q | (wd_cnt == WD_MAX) |
               (stall_c[0] && (wd_cnt == WD_MAX - WD_W'(1)));
   end

   assign stall      = stall_c;
   assign flush      = (state_q == ST_FLUSH);
   assign new_pc     = new_pc_q;
   assign exc_busy_o = (state_q != ST_IDLE);
   assign wdog_o     = wdog_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed self-checking bench for pipe_ctrl.
module tb_pipe_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_if, req_id, req_ex, req_mem;
   logic [31:0] exc, epc;
   logic [5:0]  stall;
   logic        flush, busy, wdog;
   logic [31:0] new_pc, cyc;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   pipe_ctrl dut (
      .clk               (clk),
      .rst               (rst),
      .stallreq_from_if  (req_if),
      .stallreq_from_id  (req_id),
      .stallreq_from_ex  (req_ex),
      .stallreq_from_mem (req_mem),
      .excepttype_i      (exc),
      .cp0_epc_i         (epc),
      .stall             (stall),
      .flush             (flush),
      .new_pc            (new_pc),
      .exc_busy_o        (busy),
      .stall_cycles_o    (cyc),
      .wdog_o            (wdog)
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock, land 1 ns after the edge; inputs are driven here
   // and comb outputs are checked after a further settle delay.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic set_req(input logic i, input logic d, input logic e,
                          input logic m);
      req_if = i; req_id = d; req_ex = e; req_mem = m;
   endtask

   initial begin
      rst = 1'b1; set_req(1'b0, 1'b0, 1'b0, 1'b1); exc = 32'h0; epc = 32'h0;
      tick(); tick();
      settle();
      check("rst_stall", {26'd0, stall}, 32'h00);
      check("rst_flush", {31'd0, flush}, 32'h0);
      check("rst_new_pc", new_pc, 32'h0);
      check("rst_busy", {31'd0, busy}, 32'h0);
      check("rst_cycles", cyc, 32'h0);
      check("rst_wdog", {31'd0, wdog}, 32'h0);

      rst = 1'b0; set_req(1'b0, 1'b0, 1'b0, 1'b0);
      tick();

      // Single requests and all-high, one cycle each: 5 stalled cycles.
      set_req(1'b1, 1'b0, 1'b0, 1'b0); settle();
      check("stall_if", {26'd0, stall}, 32'h07); tick();
      set_req(1'b0, 1'b1, 1'b0, 1'b0); settle();
      check("stall_id", {26'd0, stall}, 32'h07); tick();
      set_req(1'b0, 1'b0, 1'b1, 1'b0); settle();
      check("stall_ex", {26'd0, stall}, 32'h0F); tick();
      set_req(1'b0, 1'b0, 1'b0, 1'b1); settle();
      check("stall_mem", {26'd0, stall}, 32'h1F); tick();
      set_req(1'b1, 1'b1, 1'b1, 1'b1); settle();
      check("stall_all_req", {26'd0, stall}, 32'h1F); tick();
      set_req(1'b0, 1'b0, 1'b0, 1'b0); settle();
      check("stall_none", {26'd0, stall}, 32'h00);
      check("cycles_5", cyc, 32'd5);
      tick();

      // syscall, mem idle, exception overrides an EX request.
      exc = 32'h8; epc = 32'h44; req_ex = 1'b1; settle();
      check("sys_detect_stall", {26'd0, stall}, 32'h3F);
      check("sys_detect_flush", {31'd0, flush}, 32'h0);
      tick();
      exc = 32'h0; settle();
      check("sys_flush", {31'd0, flush}, 32'h1);
      check("sys_new_pc", new_pc, 32'h20);
      check("sys_flush_stall", {26'd0, stall}, 32'h00);
      check("sys_flush_busy", {31'd0, busy}, 32'h1);
      tick();
      req_ex = 1'b0; settle();
      check("sys_idle_flush", {31'd0, flush}, 32'h0);
      check("sys_idle_busy", {31'd0, busy}, 32'h0);
      check("sys_hold_pc", new_pc, 32'h20);
      check("sys_idle_stall", {26'd0, stall}, 32'h00);
      check("cycles_6", cyc, 32'd6);

      // eret with mem busy; other exceptions presented in WAIT and FLUSH.
      exc = 32'hE; epc = 32'h1000; req_mem = 1'b1; settle();
      check("eret_detect_stall", {26'd0, stall}, 32'h3F);
      tick();
      exc = 32'h8; epc = 32'h2000;
      for (int i = 0; i < 3; i++) begin
         settle();
         check("eret_wait_stall", {26'd0, stall}, 32'h3F);
         check("eret_wait_busy", {31'd0, busy}, 32'h1);
         check("eret_wait_flush", {31'd0, flush}, 32'h0);
         tick();
      end
      req_mem = 1'b0; settle();
      check("eret_mem_drop_stall", {26'd0, stall}, 32'h3F);
      check("eret_mem_drop_flush", {31'd0, flush}, 32'h0);
      tick();
      exc = 32'hC; epc = 32'h3000; settle();
      check("eret_flush", {31'd0, flush}, 32'h1);
      check("eret_new_pc", new_pc, 32'h1000);
      check("eret_flush_stall", {26'd0, stall}, 32'h00);
      tick();
      exc = 32'h0; settle();
      check("eret_after_flush", {31'd0, flush}, 32'h0);
      check("eret_after_busy", {31'd0, busy}, 32'h0);
      check("eret_hold_pc", new_pc, 32'h1000);
      check("cycles_11", cyc, 32'd11);
      tick();
      settle();
      check("eret_no_second_flush", {31'd0, flush}, 32'h0);

      // Watchdog: fresh counters, EX held for exactly WDOG_LIMIT cycles.
      rst = 1'b1; tick();
      rst = 1'b0; settle();
      check("wd_cycles_reset", cyc, 32'd0);
      req_ex = 1'b1;
      repeat (1023) tick();
      settle();
      check("wd_1023_wdog", {31'd0, wdog}, 32'h0);
      check("wd_1023_cycles", cyc, 32'd1023);
      tick();
      settle();
      check("wd_1024_wdog", {31'd0, wdog}, 32'h1);
      check("wd_1024_cycles", cyc, 32'd1024);
      req_ex = 1'b0;
      tick(); tick();
      settle();
      check("wd_sticky", {31'd0, wdog}, 32'h1);
      check("wd_cycles_hold", cyc, 32'd1024);

      // Reset while waiting on the data bus.
      exc = 32'h9; epc = 32'h500; req_mem = 1'b1; tick();
      exc = 32'h0; settle();
      check("rw_busy", {31'd0, busy}, 32'h1);
      rst = 1'b1; settle();
      check("rw_stall_in_rst", {26'd0, stall}, 32'h00);
      tick();
      rst = 1'b0; req_mem = 1'b0; settle();
      check("rw_busy_after", {31'd0, busy}, 32'h0);
      check("rw_flush_after", {31'd0, flush}, 32'h0);
      check("rw_cycles_after", cyc, 32'd0);
      check("rw_wdog_after", {31'd0, wdog}, 32'h0);
      check("rw_new_pc_after", new_pc, 32'h0);
      tick(); settle();
      check("rw_no_flush_1", {31'd0, flush}, 32'h0);
      tick(); settle();
      check("rw_no_flush_2", {31'd0, flush}, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
